// File: rtl/score_grid_manager_if.sv
// Bundled ports of score_grid_manager: border-init control, cell write port and neighbour fetch port.
// With SCORE_MAX_TRACK_EN defined, the running-maximum outputs are added.
interface score_grid_manager_if #(
  parameter int IW = 8,
  parameter int W  = 9
);
  logic                init_start;
  logic                init_done;
  logic                busy;
  logic                wr_valid;
  logic [IW-1:0]       wr_i;
  logic [IW-1:0]       wr_j;
  logic signed [W-1:0] wr_data;
  logic                wr_ready;
  logic                rd_req;
  logic [IW-1:0]       rd_i;
  logic [IW-1:0]       rd_j;
  logic                rd_ready;
  logic signed [W-1:0] diag;
  logic signed [W-1:0] up;
  logic signed [W-1:0] left;
  logic                nb_valid;
  logic                err;
`ifdef SCORE_MAX_TRACK_EN
  logic signed [W-1:0] max_score;
  logic [IW-1:0]       max_i;
  logic [IW-1:0]       max_j;

  modport master (
    output init_start, wr_valid, wr_i, wr_j, wr_data, rd_req, rd_i, rd_j,
    input  init_done, busy, wr_ready, rd_ready, diag, up, left, nb_valid, err,
    input  max_score, max_i, max_j
  );
  modport slave (
    input  init_start, wr_valid, wr_i, wr_j, wr_data, rd_req, rd_i, rd_j,
    output init_done, busy, wr_ready, rd_ready, diag, up, left, nb_valid, err,
    output max_score, max_i, max_j
  );
`else
  modport master (
    output init_start, wr_valid, wr_i, wr_j, wr_data, rd_req, rd_i, rd_j,
    input  init_done, busy, wr_ready, rd_ready, diag, up, left, nb_valid, err
  );
  modport slave (
    input  init_start, wr_valid, wr_i, wr_j, wr_data, rd_req, rd_i, rd_j,
    output init_done, busy, wr_ready, rd_ready, diag, up, left, nb_valid, err
  );
`endif
endinterface

// File: rtl/score_grid_manager.sv
// Dynamic-programming score grid: border init, cell writes and 3-neighbour fetch from a 1R1W RAM.
// Optional SCORE_MAX_TRACK_EN adds a running maximum over user writes.
module score_grid_manager #(
  parameter int N   = 128,
  parameter int M   = 128,
  parameter int W   = 9,
  parameter int GAP = -1
) (
  input logic                 clk,
  input logic                 rst,
  score_grid_manager_if.slave bus
);
  localparam int IW    = $clog2(((N > M) ? N : M) + 1);
  localparam int AW    = $clog2((N + 1) * (M + 1));
  localparam int DEPTH = (N + 1) * (M + 1);
  localparam int CW    = $clog2(N + M + 1);

  localparam logic [IW-1:0] N_I   = IW'(N);
  localparam logic [IW-1:0] M_I   = IW'(M);
  localparam logic [IW-1:0] ONE_I = IW'(1);
  localparam logic [CW-1:0] M_C   = CW'(M);
  localparam logic [CW-1:0] LAST_C = CW'(N + M);

  typedef enum logic [2:0] {IDLE, RD_D, RD_U, RD_L, OUT} rd_state_e;

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return AW'(i) * AW'(M + 1) + AW'(j);
  endfunction

  // k*GAP kept to W bits; wrap on overflow is intended
  function automatic logic signed [W-1:0] border_val(input logic [CW-1:0] k);
    int prod;
    prod = GAP * int'(k);
    return W'(prod);
  endfunction

  rd_state_e           state_q, state_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                nb_valid_q, nb_valid_d;
  logic                err_q, err_d;
  logic [IW-1:0]       ri_q, ri_d, rj_q, rj_d;
  logic signed [W-1:0] diag_q, diag_d, up_q, up_d, left_q, left_d;
  logic signed [W-1:0] tdiag_q, tdiag_d, tup_q, tup_d;

  logic signed [W-1:0] mem_q [DEPTH];
  logic signed [W-1:0] rdata_q;

  logic                wr_acc, wr_oob, rd_acc, rd_oob, user_we;
  logic                ram_we;
  logic [AW-1:0]       ram_waddr, ram_raddr, init_addr;
  logic signed [W-1:0] ram_wdata, init_val;
  logic [CW-1:0]       row_k;

  assign bus.wr_ready = !busy_q;
  assign bus.rd_ready = (state_q == IDLE) && !busy_q;
  assign bus.busy     = busy_q;
  assign bus.init_done = done_q;
  assign bus.nb_valid = nb_valid_q;
  assign bus.err      = err_q;
  assign bus.diag     = diag_q;
  assign bus.up       = up_q;
  assign bus.left     = left_q;

  assign wr_acc  = bus.wr_valid && !busy_q;
  assign wr_oob  = (bus.wr_i > N_I) || (bus.wr_j > M_I);
  assign user_we = wr_acc && !wr_oob;
  assign rd_acc  = bus.rd_req && (state_q == IDLE) && !busy_q;
  assign rd_oob  = (bus.rd_i == '0) || (bus.rd_j == '0) || (bus.rd_i > N_I) || (bus.rd_j > M_I);
  assign row_k   = cnt_q - M_C;

  // Row 0 first (k = 0..M), then column 0 (k = 1..N)
  always_comb begin
    if (cnt_q <= M_C) begin
      init_addr = addr_of('0, IW'(cnt_q));
      init_val  = border_val(cnt_q);
    end else begin
      init_addr = addr_of(IW'(row_k), '0);
      init_val  = border_val(row_k);
    end
  end

  always_comb begin
    ram_we    = busy_q || user_we;
    ram_waddr = busy_q ? init_addr : addr_of(bus.wr_i, bus.wr_j);
    ram_wdata = busy_q ? init_val : bus.wr_data;
    unique case (state_q)
      RD_D:    ram_raddr = addr_of(ri_q - ONE_I, rj_q - ONE_I);
      RD_U:    ram_raddr = addr_of(ri_q - ONE_I, rj_q);
      default: ram_raddr = addr_of(ri_q, rj_q - ONE_I);
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    rdata_q <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : mem_q[ram_raddr];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    nb_valid_d = 1'b0;
    err_d      = (rd_acc && rd_oob) || (wr_acc && wr_oob);
    ri_d       = ri_q;
    rj_d       = rj_q;
    diag_d     = diag_q;
    up_d       = up_q;
    left_d     = left_q;
    tdiag_d    = tdiag_q;
    tup_d      = tup_q;

    if (busy_q) begin
      if (cnt_q == LAST_C) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (bus.init_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end

    // rdata_q trails the issued address by one state
    unique case (state_q)
      IDLE: if (rd_acc && !rd_oob) begin
        ri_d    = bus.rd_i;
        rj_d    = bus.rd_j;
        state_d = RD_D;
      end
      RD_D: state_d = RD_U;
      RD_U: begin
        tdiag_d = rdata_q;
        state_d = RD_L;
      end
      RD_L: begin
        tup_d   = rdata_q;
        state_d = OUT;
      end
      OUT: begin
        diag_d     = tdiag_q;
        up_d       = tup_q;
        left_d     = rdata_q;
        nb_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      nb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      diag_q     <= '0;
      up_q       <= '0;
      left_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      nb_valid_q <= nb_valid_d;
      err_q      <= err_d;
      diag_q     <= diag_d;
      up_q       <= up_d;
      left_q     <= left_d;
    end
  end

  always_ff @(posedge clk) begin
    ri_q    <= ri_d;
    rj_q    <= rj_d;
    tdiag_q <= tdiag_d;
    tup_q   <= tup_d;
  end

`ifdef SCORE_MAX_TRACK_EN
  logic signed [W-1:0] max_score_q, max_score_d;
  logic [IW-1:0]       max_i_q, max_i_d, max_j_q, max_j_d;

  // Strict compare: a tie keeps the earlier cell
  always_comb begin
    max_score_d = max_score_q;
    max_i_d     = max_i_q;
    max_j_d     = max_j_q;
    if (user_we && (bus.wr_data > max_score_q)) begin
      max_score_d = bus.wr_data;
      max_i_d     = bus.wr_i;
      max_j_d     = bus.wr_j;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_score_q <= {1'b1, {(W-1){1'b0}}};
      max_i_q     <= '0;
      max_j_q     <= '0;
    end else begin
      max_score_q <= max_score_d;
      max_i_q     <= max_i_d;
      max_j_q     <= max_j_d;
    end
  end

  assign bus.max_score = max_score_q;
  assign bus.max_i     = max_i_q;
  assign bus.max_j     = max_j_q;
`endif

endmodule

// File: tb/tb_score_grid_manager.sv
// Self-checking bench for score_grid_manager (N=M=4, GAP=-2) against a 2-D grid reference model.
// Max-tracking checks are compiled in when SCORE_MAX_TRACK_EN is defined.
module tb_score_grid_manager;
  localparam int N   = 4;
  localparam int M   = 4;
  localparam int W   = 9;
  localparam int GAP = -2;
  localparam int IW  = $clog2(((N > M) ? N : M) + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_grid_manager_if #(.IW(IW), .W(W)) bus ();

  score_grid_manager #(.N(N), .M(M), .W(W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic signed [W-1:0] model [0:N][0:M];
  logic signed [W-1:0] ref_max;
  int ref_mi, ref_mj;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_max_reset();
    ref_max = {1'b1, {(W-1){1'b0}}};
    ref_mi  = 0;
    ref_mj  = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.rd_ready && bus.wr_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic wr(input int i, input int j, input int d);
    bit oob;
    logic signed [W-1:0] dv;
    oob = (i > N) || (j > M);
    dv  = W'(d);
    wait_idle();
    bus.wr_valid = 1'b1;
    bus.wr_i     = IW'(i);
    bus.wr_j     = IW'(j);
    bus.wr_data  = dv;
    tick();
    bus.wr_valid = 1'b0;
    chk($sformatf("wr_err(%0d,%0d)", i, j), bus.err, oob);
    if (!oob) begin
      model[i][j] = dv;
      if (dv > ref_max) begin
        ref_max = dv;
        ref_mi  = i;
        ref_mj  = j;
      end
    end
  endtask

  task automatic fetch(input int i, input int j);
    bit oob;
    int lat;
    logic signed [W-1:0] ed, eu, el;
    oob = (i == 0) || (j == 0) || (i > N) || (j > M);
    wait_idle();
    bus.rd_req = 1'b1;
    bus.rd_i   = IW'(i);
    bus.rd_j   = IW'(j);
    tick();
    bus.rd_req = 1'b0;
    chk($sformatf("rd_err(%0d,%0d)", i, j), bus.err, oob);
    if (oob) begin
      chk("oob_stays_idle", bus.rd_ready, 1);
      lat = 0;
      repeat (6) begin
        tick();
        if (bus.nb_valid) lat++;
      end
      chk("oob_no_nb_valid", lat, 0);
    end else begin
      ed  = model[i-1][j-1];
      eu  = model[i-1][j];
      el  = model[i][j-1];
      lat = 0;
      while (!bus.nb_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("nb_latency(%0d,%0d)", i, j), lat, 4);
      chk($sformatf("diag(%0d,%0d)", i, j), bus.diag, ed);
      chk($sformatf("up(%0d,%0d)", i, j), bus.up, eu);
      chk($sformatf("left(%0d,%0d)", i, j), bus.left, el);
      tick();
      chk("nb_valid_pulse", bus.nb_valid, 0);
      chk("diag_hold", bus.diag, ed);
    end
  endtask

  task automatic run_init();
    int busy_cnt = 0;
    bit done_seen = 0;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) chk("ready_low_while_busy", bus.wr_ready | bus.rd_ready, 0);
      if (bus.busy) busy_cnt++;
      else if (bus.init_done) begin
        done_seen = 1;
        break;
      end
      bus.init_start = (c == 3);
      tick();
    end
    bus.init_start = 1'b0;
    chk("init_busy_cycles", busy_cnt, N + M + 1);
    chk("init_done_seen", done_seen, 1);
    tick();
    chk("init_done_pulse", bus.init_done, 0);
    chk("busy_after_init", bus.busy, 0);
    for (int k = 0; k <= M; k++) model[0][k] = W'(k * GAP);
    for (int k = 1; k <= N; k++) model[k][0] = W'(k * GAP);
  endtask

  initial begin
    int cnt;
    bus.init_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_i       = '0;
    bus.wr_j       = '0;
    bus.wr_data    = '0;
    bus.rd_req     = 1'b0;
    bus.rd_i       = '0;
    bus.rd_j       = '0;
    model_max_reset();

    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_nb_valid", bus.nb_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_diag", bus.diag, 0);
    chk("rst_up", bus.up, 0);
    chk("rst_left", bus.left, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_rd_ready", bus.rd_ready, 1);
    chk("post_rst_wr_ready", bus.wr_ready, 1);
`ifdef SCORE_MAX_TRACK_EN
    chk("rst_max_score", bus.max_score, -256);
    chk("rst_max_i", bus.max_i, 0);
`endif

    run_init();
`ifdef SCORE_MAX_TRACK_EN
    chk("border_not_tracked", bus.max_score, -256);
`endif
    fetch(1, 1);

`ifdef SCORE_MAX_TRACK_EN
    wr(1, 1, 3);
    wr(2, 3, 9);
    wr(3, 3, 9);
    chk("max_score", bus.max_score, 9);
    chk("max_i", bus.max_i, 2);
    chk("max_j", bus.max_j, 3);
`endif

    wr(1, 1, 5);
    wr(1, 2, -4);
    wr(2, 1, -4);
    fetch(2, 2);

    // Write (2,1) lands on the same edge that reads it as the left neighbour
    wait_idle();
    bus.rd_req = 1'b1;
    bus.rd_i   = IW'(2);
    bus.rd_j   = IW'(2);
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_i     = IW'(2);
    bus.wr_j     = IW'(1);
    bus.wr_data  = W'(7);
    tick();
    bus.wr_valid = 1'b0;
    model[2][1] = W'(7);
    tick();
    chk("wf_nb_valid", bus.nb_valid, 1);
    chk("wf_diag", bus.diag, 5);
    chk("wf_up", bus.up, -4);
    chk("wf_left", bus.left, 7);
    fetch(2, 2);

    fetch(0, 3);
    fetch(5, 2);
    wr(5, 1, 33);
    wr(1, 5, 33);
    fetch(2, 1);

    wait_idle();
    bus.rd_req   = 1'b1;
    bus.rd_i     = IW'(5);
    bus.rd_j     = IW'(2);
    bus.wr_valid = 1'b1;
    bus.wr_i     = IW'(4);
    bus.wr_j     = IW'(7);
    bus.wr_data  = W'(11);
    tick();
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    chk("dual_oob_err", bus.err, 1);
    tick();
    chk("dual_oob_err_pulse", bus.err, 0);
    fetch(4, 4);

    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= M; j++) begin
        wr(i, j, int'($urandom_range(0, 511)) - 256);
        if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(N + 1, 7)), int'($urandom_range(0, 7)), 100);
      end
    for (int n = 0; n < 20; n++) fetch(int'($urandom_range(0, N + 1)), int'($urandom_range(0, M + 1)));
`ifdef SCORE_MAX_TRACK_EN
    chk("rand_max_score", bus.max_score, ref_max);
    chk("rand_max_i", bus.max_i, ref_mi);
    chk("rand_max_j", bus.max_j, ref_mj);
`endif

    // Reset lands while the fetch is in RD_U
    wait_idle();
    bus.rd_req = 1'b1;
    bus.rd_i   = IW'(3);
    bus.rd_j   = IW'(3);
    tick();
    bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_fetch_rd_ready", bus.rd_ready, 1);
    chk("rst_mid_fetch_diag", bus.diag, 0);
    rst = 1'b1;
    model_max_reset();
    cnt = 0;
    repeat (8) begin
      tick();
      if (bus.nb_valid) cnt++;
    end
    chk("rst_mid_fetch_no_nb", cnt, 0);
`ifdef SCORE_MAX_TRACK_EN
    chk("rst_mid_max_score", bus.max_score, ref_max);
`endif

    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid_init_busy", bus.busy, 0);
    cnt = 0;
    repeat (15) begin
      tick();
      if (bus.init_done || bus.busy) cnt++;
    end
    chk("rst_mid_init_no_done", cnt, 0);

    fetch(2, 2);
    fetch(4, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/score_grid_manager.md
SCORE_GRID_MANAGER -- requirements
Module: score_grid_manager

Interface
REQ-001 SHALL have parameter N, default 128: length of sequence A, which sets row count N+1.
REQ-002 SHALL have parameter M, default 128: length of sequence B, which sets column count M+1.
REQ-003 SHALL have parameter W, default 9: score width, two's complement.
REQ-004 SHALL have parameter GAP, default -1: signed gap penalty used for border init.
REQ-005 SHALL derive IW = $clog2(max(N,M)+1) and AW = $clog2((N+1)*(M+1)).
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port init_start, input, 1: pulse that starts border initialisation.
REQ-009 SHALL have port init_done, output, 1: one-cycle pulse when border init completes.
REQ-010 SHALL have port wr_valid, input, 1: cell write request.
REQ-011 SHALL have ports wr_i and wr_j, input, IW: cell coordinates of the write.
REQ-012 SHALL have port wr_data, input, W: cell score to write.
REQ-013 SHALL have port wr_ready, output, 1: write is accepted when wr_valid and wr_ready are both high.
REQ-014 SHALL have port rd_req, input, 1: neighbour fetch request.
REQ-015 SHALL have ports rd_i and rd_j, input, IW: coordinates of the target cell.
REQ-016 SHALL have port rd_ready, output, 1: fetch is accepted when rd_req and rd_ready are both high.
REQ-017 SHALL have ports diag, up and left, output, W: the neighbours (i-1,j-1), (i-1,j) and (i,j-1).
REQ-018 SHALL have port nb_valid, output, 1: one-cycle pulse marking diag/up/left valid.
REQ-019 SHALL have port err, output, 1: one-cycle pulse on an out-of-range request.
REQ-020 SHALL have port busy, output, 1: high while border init runs.

Function
REQ-021 SHALL contain internal (N+1)*(M+1)-word x W RAM: one sync write port, one sync read port, read latency 1, cell address i*(M+1)+j.
REQ-022 SHALL resolve read and write to the same address in the same cycle write-first: the read returns wr_data.
REQ-023 SHALL, on init_start while idle, write cell (0,k) = k*GAP for k=0..M, then cell (k,0) = k*GAP for k=1..N, one write per cycle.
REQ-024 SHALL keep busy high for exactly N+M+1 cycles during border init, then pulse init_done in the following cycle.
REQ-025 SHALL compute border products at W bits, truncating on overflow, with no saturation.
REQ-026 SHALL hold wr_ready and rd_ready low while busy; init_start while busy is ignored.
REQ-027 SHALL run a read FSM with states IDLE, RD_D, RD_U, RD_L, OUT; rd_ready = (state==IDLE) & !busy.
REQ-028 SHALL capture rd_i/rd_j on acceptance and go IDLE->RD_D->RD_U->RD_L->OUT->IDLE, one state per cycle.
REQ-029 SHALL issue the diag, up and left addresses in RD_D, RD_U and RD_L respectively.
REQ-030 SHALL pulse nb_valid in OUT, i.e. exactly 4 cycles after the accepting edge.
REQ-031 SHALL hold diag/up/left stable until the next nb_valid.
REQ-032 SHALL, on acceptance with rd_i==0, rd_j==0, rd_i>N or rd_j>M: pulse err next cycle, stay IDLE, not pulse nb_valid.
REQ-033 SHALL, on a write with wr_i>N or wr_j>M: pulse err, with no RAM write.
REQ-034 SHALL let writes be accepted in any FSM state when not busy, so fetch and write can overlap.
REQ-035 SHALL pulse err when a read and a write are both out of range in the same cycle; a single pulse suffices.

Reset
REQ-036 SHALL, while rst==0 at a clock edge, set state IDLE, busy=0, init_done=0, nb_valid=0, err=0, diag=up=left=0 and the init counter to 0.
REQ-037 SHALL not clear RAM contents on reset.
REQ-038 SHALL abort any in-progress init or fetch on reset mid-operation, with no init_done and no nb_valid.
REQ-039 SHALL drive rd_ready=1 and wr_ready=1 in the first cycle after reset deassertion.

Configuration
REQ-040 SHALL, when SCORE_MAX_TRACK_EN is defined, add outputs max_score (W), max_i (IW) and max_j (IW).
REQ-041 SHALL, with SCORE_MAX_TRACK_EN, update max_score/max_i/max_j on each accepted in-range write when wr_data > max_score (signed, strict; ties keep the earlier cell).
REQ-042 SHALL, with SCORE_MAX_TRACK_EN, reset max_score to the most negative W-bit value and max_i/max_j to 0; border-init writes are not tracked.
REQ-043 SHALL, without SCORE_MAX_TRACK_EN, omit these ports and the tracking logic entirely.

Verification
REQ-044 SHALL cover: N=M=4, GAP=-2, init_start -> busy 9 cycles, init_done pulse, fetch (1,1) gives diag=0, up=-2, left=-2.
REQ-045 SHALL cover: write (1,1)=5, then fetch (2,2) -> diag=5, up=-4, left=-4, nb_valid 4 cycles after acceptance.
REQ-046 SHALL cover: write (2,1)=7 in the same cycle RD_L addresses (2,1) -> left=7 (write-first).
REQ-047 SHALL cover: fetch (0,3) and write (5,1) with N=4 -> err pulses, no nb_valid, RAM unchanged.
REQ-048 SHALL cover: rst=0 in RD_U -> next cycle rd_ready=1, nb_valid never asserts.
REQ-049 SHALL cover, with SCORE_MAX_TRACK_EN: writes 3@(1,1), 9@(2,3), 9@(3,3) -> max_score=9, max_i=2, max_j=3.
